// File: rtl/ifu_fetch_buf_if.sv
// Handshake bundle between the fetch buffer, the IFU PC generator, imem and the IDU.
// The slave modport is the buffer side and the master modport is the environment side.
interface ifu_fetch_buf_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  flush;
    logic                  idu_valid;
    logic                  idu_ready;
    logic [ADDR_WIDTH-1:0] idu_pc;
    logic [DATA_WIDTH-1:0] idu_inst;
    logic [CNT_WIDTH-1:0]  buf_cnt;

    modport slave (
        input  req_valid, req_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, idu_ready,
        output req_ready, mem_req_valid, mem_req_addr, idu_valid, idu_pc, idu_inst, buf_cnt
    );

    modport master (
        output req_valid, req_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, idu_ready,
        input  req_ready, mem_req_valid, mem_req_addr, idu_valid, idu_pc, idu_inst, buf_cnt
    );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Fetch response buffer: issues IFU PCs to imem in order, pairs each returning word with its PC,
// and queues the pairs for the IDU. A redirect discards buffered entries and drops in-flight replies.
module ifu_fetch_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic          i_sys_clk,
    input  logic          i_sys_rst,
    ifu_fetch_buf_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      alloc_ptr, rsp_ptr, head_ptr, drop_cnt, drop_next;
    logic [PTR_W-1:0]      buf_cnt, in_flight;
    logic [PTR_W:0]        used;
    logic [IDX_W-1:0]      alloc_idx, rsp_idx, head_idx;
    logic [DEPTH-1:0]      filled;
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic                  credit, req_fire, rsp_any, rsp_keep, idu_fire;

    assign alloc_idx = alloc_ptr[IDX_W-1:0];
    assign rsp_idx   = rsp_ptr[IDX_W-1:0];
    assign head_idx  = head_ptr[IDX_W-1:0];

    assign buf_cnt   = alloc_ptr - head_ptr;
    assign in_flight = alloc_ptr - rsp_ptr;
    assign used      = {1'b0, buf_cnt} + {1'b0, drop_cnt};
    assign credit    = used < DEPTH_CNT;

    // The IFU and imem handshakes are one event, so both readies share the same qualifiers.
    assign bus.mem_req_valid = bus.req_valid & credit & ~bus.flush;
    assign bus.req_ready     = bus.mem_req_ready & credit & ~bus.flush;
    assign bus.mem_req_addr  = bus.req_pc;
    assign req_fire          = bus.req_valid & bus.req_ready;

    // A reply with nothing outstanding (neither dropped nor live) is a protocol error and is ignored.
    assign rsp_any  = bus.mem_rsp_valid & ((drop_cnt != '0) | (in_flight != '0));
    assign rsp_keep = rsp_any & (drop_cnt == '0) & ~bus.flush;

    assign bus.idu_valid = filled[head_idx];
    assign bus.idu_pc    = bus.idu_valid ? pc_mem[head_idx]   : '0;
    assign bus.idu_inst  = bus.idu_valid ? inst_mem[head_idx] : '0;
    assign bus.buf_cnt   = buf_cnt;
    assign idu_fire      = bus.idu_valid & bus.idu_ready & ~bus.flush;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        drop_next = drop_cnt;
        if (bus.flush) begin
            drop_next = drop_cnt + in_flight - {{(PTR_W-1){1'b0}}, rsp_any};
        end else if (rsp_any && (drop_cnt != '0)) begin
            drop_next = drop_cnt - PTR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            alloc_ptr <= '0;
            rsp_ptr   <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (bus.flush) begin
                rsp_ptr  <= alloc_ptr;
                head_ptr <= alloc_ptr;
                filled   <= '0;
            end else begin
                if (req_fire) begin
                    alloc_ptr         <= alloc_ptr + PTR_ONE;
                    filled[alloc_idx] <= 1'b0;
                end
                if (idu_fire) begin
                    head_ptr         <= head_ptr + PTR_ONE;
                    filled[head_idx] <= 1'b0;
                end
                if (rsp_keep) begin
                    rsp_ptr         <= rsp_ptr + PTR_ONE;
                    filled[rsp_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the payload arrays are not reset; filled[] gates them, so their contents never leak out.
    always_ff @(posedge i_sys_clk) begin
        if (req_fire) pc_mem[alloc_idx]  <= bus.req_pc;
        if (rsp_keep) inst_mem[rsp_idx]  <= bus.mem_rsp_data;
    end
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Directed bench for ifu_fetch_buf: single fetch, fill, backpressure, flush, flush collision, async reset.
module tb_ifu_fetch_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_buf_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) bus ();

    ifu_fetch_buf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid     = 1'b0;
        bus.req_pc        = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.flush         = 1'b0;
        bus.idu_ready     = 1'b0;
    endtask

    task automatic single_fetch(input string tag);
        idle();
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h8000_0000;
        #1;
        check({tag, "_mem_valid"}, 64'(bus.mem_req_valid), 64'd1);
        check({tag, "_mem_addr"},  64'(bus.mem_req_addr),  64'h8000_0000);
        check({tag, "_req_ready"}, 64'(bus.req_ready),     64'd1);
        step();
        idle();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0013;
        #1;
        check({tag, "_cnt_inflight"},  64'(bus.buf_cnt),   64'd1);
        check({tag, "_no_bypass"},     64'(bus.idu_valid), 64'd0);
        step();
        idle();
        bus.idu_ready = 1'b1;
        #1;
        check({tag, "_valid"},    64'(bus.idu_valid), 64'd1);
        check({tag, "_pc"},       64'(bus.idu_pc),    64'h8000_0000);
        check({tag, "_inst"},     64'(bus.idu_inst),  64'h0000_0013);
        check({tag, "_cnt_full"}, 64'(bus.buf_cnt),   64'd1);
        step();
        idle();
        #1;
        check({tag, "_cnt_after"},   64'(bus.buf_cnt),   64'd0);
        check({tag, "_valid_after"}, 64'(bus.idu_valid), 64'd0);
    endtask

    task automatic drive_req(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
    endtask

    task automatic drive_rsp(input logic [31:0] data);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
    endtask

    initial begin
        logic [31:0] rspq[$];
        int          issued;
        int          got;
        bit          stall;
        logic [31:0] held_pc, held_inst;

        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.idu_valid), 64'd0);
        check("rst_pc",    64'(bus.idu_pc),    64'd0);
        check("rst_inst",  64'(bus.idu_inst),  64'd0);
        check("rst_cnt",   64'(bus.buf_cnt),   64'd0);
        rst = 1'b0;
        step();

        // Scenario 1: single fetch
        single_fetch("s1");

        // Scenario 2: fill to DEPTH, fifth request blocked, one dequeue reopens credit
        idle(); drive_req(32'h10); step();
        idle(); drive_req(32'h14); drive_rsp(32'h1010); step();
        idle(); drive_req(32'h18); drive_rsp(32'h1014); step();
        idle(); drive_req(32'h1C); drive_rsp(32'h1018); step();
        idle(); drive_req(32'h20); drive_rsp(32'h101C); #1;
        check("s2_fifth_blocked", 64'(bus.req_ready),     64'd0);
        check("s2_fifth_no_mem",  64'(bus.mem_req_valid), 64'd0);
        check("s2_cnt_full",      64'(bus.buf_cnt),       64'd4);
        step();
        idle(); bus.idu_ready = 1'b1; #1;
        check("s2_still_blocked", 64'(bus.req_ready), 64'd0);
        check("s2_head_pc",       64'(bus.idu_pc),    64'h10);
        step();
        idle(); bus.idu_ready = 1'b1; #1;
        check("s2_ready_back", 64'(bus.req_ready), 64'd1);
        check("s2_cnt_3",      64'(bus.buf_cnt),   64'd3);
        check("s2_pc1",        64'(bus.idu_pc),    64'h14);
        step();
        idle(); bus.idu_ready = 1'b1; #1;
        check("s2_pc2", 64'(bus.idu_pc), 64'h18);
        step();
        idle(); bus.idu_ready = 1'b1; #1;
        check("s2_pc3",   64'(bus.idu_pc),   64'h1C);
        check("s2_inst3", 64'(bus.idu_inst), 64'h101C);
        step();
        idle(); #1;
        check("s2_empty", 64'(bus.buf_cnt), 64'd0);

        // Scenario 3: eight fetches with toggling IDU backpressure
        issued = 0;
        got    = 0;
        stall  = 1'b0;
        held_pc   = '0;
        held_inst = '0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            idle();
            bus.req_valid = (issued < 8);
            bus.req_pc    = 32'(issued * 4);
            if (rspq.size() > 0) drive_rsp(rspq.pop_front());
            bus.idu_ready = ((cyc % 2) == 1);
            #1;
            if (stall) begin
                check("s3_hold_valid", 64'(bus.idu_valid), 64'd1);
                check("s3_hold_pc",    64'(bus.idu_pc),    64'(held_pc));
                check("s3_hold_inst",  64'(bus.idu_inst),  64'(held_inst));
            end
            if (bus.idu_valid && bus.idu_ready) begin
                check("s3_pc",   64'(bus.idu_pc),   64'(got * 4));
                check("s3_inst", 64'(bus.idu_inst), 64'(32'h100 + got * 4));
                got++;
            end
            stall     = bus.idu_valid & ~bus.idu_ready;
            held_pc   = bus.idu_pc;
            held_inst = bus.idu_inst;
            if (bus.req_valid && bus.req_ready) begin
                rspq.push_back(32'(32'h100 + issued * 4));
                issued++;
            end
            step();
        end
        check("s3_count", 64'(got), 64'd8);
        idle(); #1;
        check("s3_empty", 64'(bus.buf_cnt), 64'd0);

        // Scenario 4: flush with two in flight and one buffered
        idle(); drive_req(32'h40); step();
        idle(); drive_req(32'h44); drive_rsp(32'hA0); step();
        idle(); drive_req(32'h48); #1;
        check("s4_buffered", 64'(bus.idu_valid), 64'd1);
        step();
        idle(); bus.flush = 1'b1; drive_req(32'h999); #1;
        check("s4_flush_no_ready", 64'(bus.req_ready),     64'd0);
        check("s4_flush_no_mem",   64'(bus.mem_req_valid), 64'd0);
        check("s4_cnt_pre",        64'(bus.buf_cnt),       64'd3);
        step();
        idle(); drive_req(32'h100); #1;
        check("s4_drop_cnt", 64'(dut.drop_cnt), 64'd2);
        check("s4_cnt_zero", 64'(bus.buf_cnt),  64'd0);
        check("s4_empty",    64'(bus.idu_valid), 64'd0);
        check("s4_resume",   64'(bus.req_ready), 64'd1);
        step();
        idle(); drive_rsp(32'hDEAD_0001); #1;
        check("s4_cnt_new", 64'(bus.buf_cnt), 64'd1);
        step();
        idle(); drive_rsp(32'hDEAD_0002); #1;
        check("s4_drop_1",     64'(dut.drop_cnt),  64'd1);
        check("s4_no_output1", 64'(bus.idu_valid), 64'd0);
        step();
        idle(); drive_rsp(32'h0000_0113); #1;
        check("s4_drop_0",     64'(dut.drop_cnt),  64'd0);
        check("s4_no_output2", 64'(bus.idu_valid), 64'd0);
        step();
        idle(); bus.idu_ready = 1'b1; #1;
        check("s4_valid", 64'(bus.idu_valid), 64'd1);
        check("s4_pc",    64'(bus.idu_pc),    64'h100);
        check("s4_inst",  64'(bus.idu_inst),  64'h113);
        step();
        idle(); #1;
        check("s4_drained", 64'(bus.buf_cnt), 64'd0);

        // Scenario 5: flush, response and IDU handshake in the same cycle
        idle(); drive_req(32'h200); step();
        idle(); drive_req(32'h204); drive_rsp(32'h300); step();
        idle(); bus.flush = 1'b1; bus.idu_ready = 1'b1; drive_rsp(32'h304); #1;
        check("s5_pre_valid", 64'(bus.idu_valid), 64'd1);
        check("s5_pre_pc",    64'(bus.idu_pc),    64'h200);
        check("s5_pre_cnt",   64'(bus.buf_cnt),   64'd2);
        step();
        idle(); #1;
        check("s5_valid", 64'(bus.idu_valid), 64'd0);
        check("s5_cnt",   64'(bus.buf_cnt),   64'd0);
        check("s5_drop",  64'(dut.drop_cnt),  64'd0);
        check("s5_ready", 64'(bus.req_ready), 64'd1);
        step();
        idle(); #1;
        check("s5_no_late_output", 64'(bus.idu_valid), 64'd0);

        // Scenario 6: asynchronous reset with three fetches in flight
        idle(); drive_req(32'h500); step();
        idle(); drive_req(32'h504); drive_rsp(32'h600); step();
        idle(); drive_req(32'h508); step();
        idle(); drive_req(32'h50C); step();
        idle(); #1;
        check("s6_pre_cnt",   64'(bus.buf_cnt),   64'd4);
        check("s6_pre_valid", 64'(bus.idu_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_valid", 64'(bus.idu_valid), 64'd0);
        check("s6_pc",    64'(bus.idu_pc),    64'd0);
        check("s6_inst",  64'(bus.idu_inst),  64'd0);
        check("s6_cnt",   64'(bus.buf_cnt),   64'd0);
        check("s6_drop",  64'(dut.drop_cnt),  64'd0);
        #1;
        rst = 1'b0;
        step();
        single_fetch("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
